// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes, funct encodings and FSM states shared by the shift execute stage
// Contents: shift_op_t and OP_* codes, F3_* / F7_* encodings, shift_state_e,
//           op_is_rotate() helper.
package shift_pkg;

    typedef logic [2:0] shift_op_t;

    localparam shift_op_t OP_SLL = 3'd0;
    localparam shift_op_t OP_SRL = 3'd1;
    localparam shift_op_t OP_SRA = 3'd2;
    localparam shift_op_t OP_ROL = 3'd3;
    localparam shift_op_t OP_ROR = 3'd4;
    localparam shift_op_t OP_ILL = 3'd5;

    localparam logic [2:0] F3_SL = 3'b001;
    localparam logic [2:0] F3_SR = 3'b101;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ARITH = 7'b0100000;
    localparam logic [6:0] F7_ROT   = 7'b0110000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2
    } shift_state_e;

    function automatic logic op_is_rotate(input shift_op_t op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/BarrelShifter.sv
// rtl/BarrelShifter.sv - log-stage barrel shifter, left/right, logical/arithmetic
// Ports: A (value), shamt (amount), arith (sign fill on right shifts),
//        right (1 = right shift), O (result).
module BarrelShifter #(
    parameter int width     = 32,
    parameter int bitLength = 5
) (
    input  logic [width-1:0]     A,
    input  logic [bitLength-1:0] shamt,
    input  logic                 arith,
    input  logic                 right,
    output logic [width-1:0]     O
);

    // Left shifts reuse the right-shift network by bit-reversing in and out.
    logic [width-1:0]                a_rev;
    logic [width-1:0]                o_rev;
    logic [bitLength:0][width-1:0]   stage;
    logic                            fill;

    assign fill = arith & right & A[width-1];

    for (genvar i = 0; i < width; i++) begin : g_rev
        assign a_rev[i] = A[width-1-i];
        assign o_rev[i] = stage[bitLength][width-1-i];
    end

    assign stage[0] = right ? A : a_rev;

    for (genvar k = 0; k < bitLength; k++) begin : g_stage
        assign stage[k+1] = shamt[k] ? {{(2**k){fill}}, stage[k][width-1:2**k]} : stage[k];
    end

    assign O = right ? stage[bitLength] : o_rev;

endmodule

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - funct3/funct7/is_imm to shift op decoder (rotates under SHIFT_EXEC_ROTATE_EN)
// Ports: funct3_i, funct7_i, is_imm_i in; op_o (shift_op_t) out. Purely combinational.
module shift_decode
    import shift_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       is_imm_i,
    output shift_op_t  op_o
);

    always_comb begin
        op_o = OP_ILL;
        if (funct3_i == F3_SL && funct7_i == F7_BASE) begin
            op_o = OP_SLL;
        end else if (funct3_i == F3_SR && funct7_i == F7_BASE) begin
            op_o = OP_SRL;
        end else if (funct3_i == F3_SR && funct7_i == F7_ARITH) begin
            op_o = OP_SRA;
`ifdef SHIFT_EXEC_ROTATE_EN
        // There is no ROLI encoding; only the register form rotates left.
        end else if (funct3_i == F3_SL && funct7_i == F7_ROT && !is_imm_i) begin
            op_o = OP_ROL;
        end else if (funct3_i == F3_SR && funct7_i == F7_ROT) begin
            op_o = OP_ROR;
`endif
        end
    end

`ifndef SHIFT_EXEC_ROTATE_EN
    logic is_imm_unused;
    assign is_imm_unused = is_imm_i;
`endif

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage RV32 shift execute slice (rotates under SHIFT_EXEC_ROTATE_EN)
// Ports: clk, rst_n (async, active-low), flush;
//        in_* : decoded operand bundle with in_valid/in_ready handshake;
//        out_*: registered result, rd and illegal flag with out_valid/out_ready.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic               in_is_imm,
    input  logic [WIDTH-1:0]   in_rs1,
    input  logic [WIDTH-1:0]   in_rs2,
    input  logic [SHAMT_W-1:0] in_shamt_imm,
    input  logic [RD_W-1:0]    in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [RD_W-1:0]    out_rd,
    output logic               out_illegal
);

    shift_state_e        state_q, state_d;
    logic [WIDTH-1:0]    rs1_q;
    logic [SHAMT_W-1:0]  shamt_q;
    logic [RD_W-1:0]     rd_q;
    shift_op_t           op_q;

    logic                out_valid_q;
    logic [WIDTH-1:0]    out_result_q;
    logic [RD_W-1:0]     out_rd_q;
    logic                out_illegal_q;

    shift_op_t           dec_op;
    logic [SHAMT_W-1:0]  shamt_sel;
    logic                s1_valid, s1_adv, out_free, accept, in_ready_c, rot_op;
    logic                sh_right, sh_arith;
    logic [SHAMT_W-1:0]  sh_amt;
    logic [WIDTH-1:0]    sh_out, result_c;

    logic [WIDTH-SHAMT_W-1:0] rs2_unused;
    assign rs2_unused = in_rs2[WIDTH-1:SHAMT_W];

    shift_decode u_decode (
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .is_imm_i (in_is_imm),
        .op_o     (dec_op)
    );

    assign shamt_sel = in_is_imm ? in_shamt_imm : in_rs2[SHAMT_W-1:0];

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [WIDTH-1:0] partial_q;
    assign rot_op = op_is_rotate(op_q);
`else
    assign rot_op = 1'b0;
`endif

    BarrelShifter #(
        .width     (WIDTH),
        .bitLength (SHAMT_W)
    ) u_shifter (
        .A     (rs1_q),
        .O     (sh_out),
        .shamt (sh_amt),
        .arith (sh_arith),
        .right (sh_right)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = ST_PASS1;
                end
                ST_PASS1: begin
                    if (rot_op)      state_d = ST_PASS2;
                    else if (s1_adv) state_d = accept ? ST_PASS1 : ST_IDLE;
                end
`ifdef SHIFT_EXEC_ROTATE_EN
                ST_PASS2: begin
                    if (s1_adv) state_d = accept ? ST_PASS1 : ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: handshake and shifter controls.
    always_comb begin
        s1_valid = (state_q != ST_IDLE);
        out_free = !out_valid_q || out_ready;
        s1_adv   = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_PASS1: s1_adv = out_free && !rot_op;
`ifdef SHIFT_EXEC_ROTATE_EN
                ST_PASS2: s1_adv = out_free;
`endif
                default:  s1_adv = 1'b0;
            endcase
        end
        // rst_n gates in_ready so upstream never sees a transfer during reset.
        in_ready_c = rst_n && !flush && (!s1_valid || s1_adv);
        accept     = in_valid && in_ready_c;

        sh_right = (op_q == OP_SRL) || (op_q == OP_SRA);
        sh_arith = (op_q == OP_SRA);
        sh_amt   = shamt_q;
        result_c = sh_out;
`ifdef SHIFT_EXEC_ROTATE_EN
        if (state_q == ST_PASS1 && op_q == OP_ROR) begin
            sh_right = 1'b1;
        end
        // Second pass shifts the other way by WIDTH-shamt; shamt=0 wraps to 0
        // so both passes return rs1 and the OR stays rs1.
        if (state_q == ST_PASS2) begin
            sh_right = (op_q == OP_ROL);
            sh_arith = 1'b0;
            sh_amt   = SHAMT_W'(0) - shamt_q;
            result_c = partial_q | sh_out;
        end
`endif
        if (op_q == OP_ILL) begin
            result_c = '0;
        end
    end

    // Stage-1 operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= '0;
            shamt_q <= '0;
            rd_q    <= '0;
            op_q    <= OP_ILL;
        end else if (accept) begin
            rs1_q   <= in_rs1;
            shamt_q <= shamt_sel;
            rd_q    <= in_rd;
            op_q    <= dec_op;
        end
    end

`ifdef SHIFT_EXEC_ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q <= '0;
        end else if (state_q == ST_PASS1 && rot_op && !flush) begin
            partial_q <= sh_out;
        end
    end
`endif

    // Output register toward writeback; data only changes on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= result_c;
            out_rd_q      <= rd_q;
            out_illegal_q <= (op_q == OP_ILL);
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - scoreboard bench for shift_exec_stage
module tb_shift_exec_stage;

    typedef struct packed {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  shi;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic        in_is_imm = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_shamt_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    op_t  ops[$];

    always #5 clk = ~clk;

    shift_exec_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_is_imm    (in_is_imm),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_shamt_imm (in_shamt_imm),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_illegal  (out_illegal)
    );

    function automatic op_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [4:0] shi, input logic [4:0] rd);
        op_t o;
        o.f3 = f3; o.f7 = f7; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2; o.shi = shi; o.rd = rd;
        return o;
    endfunction

    function automatic logic is_rot(input op_t o);
        return (o.f7 == 7'h30) && ((o.f3 == 3'b101) || (o.f3 == 3'b001 && !o.imm));
    endfunction

    // Reference model of the RV32 shift semantics.
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [4:0]  s;
        logic [63:0] d;
        s = o.imm ? o.shi : o.rs2[4:0];
        d = {o.rs1, o.rs1};
        e.rd = o.rd; e.ill = 1'b0; e.res = '0;
        if (o.f3 == 3'b001 && o.f7 == 7'h00)      e.res = o.rs1 << s;
        else if (o.f3 == 3'b101 && o.f7 == 7'h00) e.res = o.rs1 >> s;
        else if (o.f3 == 3'b101 && o.f7 == 7'h20) e.res = $signed(o.rs1) >>> s;
`ifdef SHIFT_EXEC_ROTATE_EN
        else if (o.f3 == 3'b001 && o.f7 == 7'h30 && !o.imm) begin d = d << s; e.res = d[63:32]; end
        else if (o.f3 == 3'b101 && o.f7 == 7'h30) begin d = d >> s; e.res = d[31:0]; end
`endif
        else e.ill = 1'b1;
        return e;
    endfunction

    task automatic drive(input op_t o);
        in_funct3 = o.f3; in_funct7 = o.f7; in_is_imm = o.imm;
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_shamt_imm = o.shi; in_rd = o.rd;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_result, out_rd, out_illegal} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_result, out_rd, out_illegal});
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_sll();
        exp_t e;
        sb.delete(); ops.delete();
        ops.push_back(mk(3'b001, 7'h00, 1'b0, 32'h1, 32'd31, 5'd0, 5'd7));
        ops.push_back(mk(3'b001, 7'h00, 1'b1, 32'h1, 32'd3,  5'd0, 5'd9));
        out_ready = 1'b1;
        @(posedge clk); #1;
        foreach (ops[i]) begin
            drive(ops[i]); #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sll_in_ready: got %b expected 1", in_ready); end
            sb.push_back(model(ops[i]));
            @(posedge clk); #1; in_valid = 1'b0; #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_early: out_valid %b expected 0", out_valid); end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL sll_latency: out_valid %b expected 1", out_valid);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({out_result, out_rd, out_illegal} !== e) begin
                    n_fail++; $display("FAIL sll_result: got %h expected %h", {out_result, out_rd, out_illegal}, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   idx, cyc;
        sb.delete(); ops.delete();
        ops.push_back(mk(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 5'd0, 5'd1));
        ops.push_back(mk(3'b101, 7'h00, 1'b0, 32'h8000_0000, 32'd4, 5'd0, 5'd2));
        ops.push_back(mk(3'b101, 7'h20, 1'b1, 32'h8000_0000, 32'd0, 5'd31, 5'd3));
        ops.push_back(mk(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'hFFFF_FFE0, 5'd7, 5'd4));
        for (int i = 0; i < 8; i++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
            ops.push_back(mk(f3, (f3 == 3'b101 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                             1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom), 5'($urandom)));
        end
        out_ready = 1'b1; idx = 0; cyc = 0;
        while ((idx < ops.size() || sb.size() != 0) && cyc < 100) begin
            if (idx < ops.size()) drive(ops[idx]); else in_valid = 1'b0;
            #1;
            if (idx < ops.size()) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1 cyc %0d", in_ready, cyc); end
            end
            if (in_valid && in_ready) begin sb.push_back(model(ops[idx])); idx++; end
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: got %h expected none", {out_result, out_rd, out_illegal});
                end else begin
                    e = sb.pop_front();
                    if ({out_result, out_rd, out_illegal} !== e) begin
                        n_fail++; $display("FAIL b2b_result: got %h expected %h", {out_result, out_rd, out_illegal}, e);
                    end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc >= 100) begin n_fail++; $display("FAIL b2b_timeout: got %0d cycles expected < 100", cyc); end
    endtask

    task automatic test_backpressure();
        exp_t e, held;
        logic have_held;
        int   idx, cyc, early_acc;
        sb.delete(); ops.delete();
        ops.push_back(mk(3'b001, 7'h00, 1'b0, 32'h0000_00FF, 32'd8, 5'd0, 5'd10));
        ops.push_back(mk(3'b101, 7'h00, 1'b1, 32'hF000_0000, 32'd0, 5'd12, 5'd11));
        ops.push_back(mk(3'b101, 7'h20, 1'b0, 32'h8765_4321, 32'd16, 5'd0, 5'd12));
        idx = 0; cyc = 0; early_acc = 0; have_held = 1'b0; held = '0;
        while ((idx < ops.size() || sb.size() != 0) && cyc < 100) begin
            if (idx < ops.size()) drive(ops[idx]); else in_valid = 1'b0;
            out_ready = (cyc >= 4);
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(ops[idx])); idx++;
                if (cyc < 4) early_acc++;
            end
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    n_checks++;
                    if ({out_result, out_rd, out_illegal} !== held) begin
                        n_fail++; $display("FAIL bp_stable: got %h expected %h", {out_result, out_rd, out_illegal}, held);
                    end
                end
                held = {out_result, out_rd, out_illegal}; have_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                have_held = 1'b0;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL bp_unexpected: got %h expected none", {out_result, out_rd, out_illegal});
                end else begin
                    e = sb.pop_front();
                    if ({out_result, out_rd, out_illegal} !== e) begin
                        n_fail++; $display("FAIL bp_result: got %h expected %h", {out_result, out_rd, out_illegal}, e);
                    end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (early_acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", early_acc); end
        n_checks++;
        if (cyc >= 100) begin n_fail++; $display("FAIL bp_timeout: got %0d cycles expected < 100", cyc); end
    endtask

    task automatic test_illegal();
        exp_t e;
        int   idx, cyc, n_ill;
        sb.delete(); ops.delete();
        ops.push_back(mk(3'b000, 7'h00, 1'b0, 32'h1234_5678, 32'd3, 5'd0, 5'd13));
        ops.push_back(mk(3'b001, 7'h20, 1'b1, 32'h1234_5678, 32'd0, 5'd3, 5'd14));
        ops.push_back(mk(3'b101, 7'h01, 1'b0, 32'h1234_5678, 32'd3, 5'd0, 5'd15));
        ops.push_back(mk(3'b101, 7'h00, 1'b0, 32'h0000_00F0, 32'd4, 5'd0, 5'd16));
        out_ready = 1'b1; idx = 0; cyc = 0; n_ill = 0;
        while ((idx < ops.size() || sb.size() != 0) && cyc < 100) begin
            if (idx < ops.size()) drive(ops[idx]); else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin sb.push_back(model(ops[idx])); idx++; end
            if (out_valid) begin
                if (out_illegal) n_ill++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL ill_unexpected: got %h expected none", {out_result, out_rd, out_illegal});
                end else begin
                    e = sb.pop_front();
                    if ({out_result, out_rd, out_illegal} !== e) begin
                        n_fail++; $display("FAIL ill_result: got %h expected %h", {out_result, out_rd, out_illegal}, e);
                    end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_ill != 3) begin n_fail++; $display("FAIL ill_count: got %0d expected 3", n_ill); end
    endtask

    task automatic test_flush();
        exp_t e;
        op_t  c_op, a_op, b_op;
        sb.delete();
        c_op = mk(3'b001, 7'h00, 1'b0, 32'd3, 32'd2, 5'd0, 5'd3);
        a_op = mk(3'b101, 7'h00, 1'b0, 32'hFFFF_0000, 32'd8, 5'd0, 5'd4);
        b_op = mk(3'b001, 7'h00, 1'b1, 32'h0000_0001, 32'd0, 5'd5, 5'd5);
        out_ready = 1'b0;
        drive(c_op); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ready: got %b expected 1", in_ready); end
        sb.push_back(model(c_op));
        @(posedge clk); #1; drive(a_op); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ready2: got %b expected 1", in_ready); end
        @(posedge clk); #1; drive(b_op); flush = 1'b1; out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_held: out_valid %b expected 1", out_valid);
        end else begin
            e = sb.pop_front();
            if ({out_result, out_rd, out_illegal} !== e) begin
                n_fail++; $display("FAIL flush_held_data: got %h expected %h", {out_result, out_rd, out_illegal}, e);
            end
        end
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak: out_valid %b expected 0", out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        int   idx, cyc;
        logic last_rot, exp_rdy;
        sb.delete(); ops.delete();
        ops.push_back(mk(3'b101, 7'h30, 1'b0, 32'h0000_00F1, 32'd4, 5'd0, 5'd20));
        ops.push_back(mk(3'b001, 7'h30, 1'b0, 32'h8000_0001, 32'd1, 5'd0, 5'd21));
        ops.push_back(mk(3'b101, 7'h30, 1'b1, 32'h1234_5678, 32'd9, 5'd0, 5'd22));
        ops.push_back(mk(3'b101, 7'h30, 1'b1, 32'h1234_5678, 32'd0, 5'd8, 5'd23));
        ops.push_back(mk(3'b001, 7'h00, 1'b0, 32'h0000_0005, 32'd1, 5'd0, 5'd24));
        out_ready = 1'b1; idx = 0; cyc = 0; last_rot = 1'b0;
        while ((idx < ops.size() || sb.size() != 0) && cyc < 100) begin
            if (idx < ops.size()) drive(ops[idx]); else in_valid = 1'b0;
            #1;
            exp_rdy = 1'b1;
`ifdef SHIFT_EXEC_ROTATE_EN
            if (last_rot) exp_rdy = 1'b0;
`endif
            if (idx < ops.size()) begin
                n_checks++;
                if (in_ready !== exp_rdy) begin
                    n_fail++; $display("FAIL rot_in_ready: got %b expected %b cyc %0d", in_ready, exp_rdy, cyc);
                end
            end
            last_rot = 1'b0;
            if (in_valid && in_ready) begin
                last_rot = is_rot(ops[idx]);
                sb.push_back(model(ops[idx])); idx++;
            end
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rot_unexpected: got %h expected none", {out_result, out_rd, out_illegal});
                end else begin
                    e = sb.pop_front();
                    if ({out_result, out_rd, out_illegal} !== e) begin
                        n_fail++; $display("FAIL rot_result: got %h expected %h", {out_result, out_rd, out_illegal}, e);
                    end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc >= 100) begin n_fail++; $display("FAIL rot_timeout: got %0d cycles expected < 100", cyc); end
    endtask

    task automatic test_reset_mid();
        sb.delete();
        out_ready = 1'b0;
        drive(mk(3'b001, 7'h00, 1'b0, 32'hA5A5_A5A5, 32'd4, 5'd0, 5'd25));
        @(posedge clk); #1;
        drive(mk(3'b101, 7'h00, 1'b0, 32'hA5A5_A5A5, 32'd4, 5'd0, 5'd26));
        @(posedge clk); #1; in_valid = 1'b0; #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: out_valid %b expected 1", out_valid); end
        rst_n = 1'b0; #1;
        n_checks++;
        if ({out_valid, out_result, out_rd, out_illegal} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", {out_valid, out_result, out_rd, out_illegal});
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release: in_ready %b expected 1", in_ready); end
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_leak: out_valid %b expected 0", out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sll();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_rotate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage execute-unit slice that owns all RV32 shift instructions: SLL/SRL/SRA and their immediate forms.
- Accepts decoded operands from the ID/EX handshake and decodes funct3/funct7 into shifter controls.
- Drives one instance of the existing BarrelShifter module (ports A, O, shamt, arith, right). Registers the result toward writeback with valid/ready flow control.
- Sits between the decode issue port and the EX/MEM result arbiter.

Parameters:
- WIDTH, 32: datapath width, passed to BarrelShifter `width`.
- SHAMT_W, 5: shift-amount width, passed to BarrelShifter `bitLength`. WIDTH == 2**SHAMT_W is required.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill in-flight stage-1 op (branch mispredict/trap).
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept the bundle this cycle.
- in_funct3  in  3  instruction funct3.
- in_funct7  in  7  instruction funct7, or imm[11:5] for immediate forms.
- in_is_imm  in  1  1 = OP-IMM form.
- in_rs1  in  WIDTH  value to shift.
- in_rs2  in  WIDTH  register shift amount (low SHAMT_W bits used).
- in_shamt_imm  in  SHAMT_W  immediate shift amount.
- in_rd  in  RD_W  destination index.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  shifted value.
- out_rd  out  RD_W  destination index.
- out_illegal  out  1  encoding not a supported shift.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_result=0, out_rd=0, out_illegal=0, FSM=IDLE. Takes effect immediately, mid-operation included; in_ready=0 while in reset.
- Accept: transfer occurs when in_valid && in_ready. in_ready = !flush && (!s1_valid || s1_adv).
- Stage 1 latches:
  - rs1.
  - shamt = in_is_imm ? in_shamt_imm : in_rs2[SHAMT_W-1:0].
  - rd.
  - Decoded op: SLL, SRL, SRA, ROL, ROR, or ILL.
- Decode:
  - funct3=001 & funct7=0000000 → SLL.
  - funct3=101 & funct7=0000000 → SRL.
  - funct3=101 & funct7=0100000 → SRA.
  - Everything else → ILL (see Optional Feature for rotates).
- Shifter controls, taken from the stage-1 register:
  - right = (SRL|SRA|ROR-pass1|ROL-pass2).
  - arith = SRA.
- FSM (stage 1): IDLE, PASS1, PASS2.
  - Accept → PASS1.
  - PASS1 with non-rotate op: result ready combinationally. s1_adv = (!out_valid || out_ready). On s1_adv, go to PASS1 if a new op is accepted the same cycle, else IDLE.
  - PASS2 is used only by rotates.
- Latency and throughput:
  - Op accepted at edge N → out_valid=1 after edge N+1.
  - Back-to-back ops sustain 1/cycle when out_ready=1.
- Output register:
  - Loads {result, rd, illegal} on s1_adv.
  - out_valid clears on out_ready when no new load occurs.
  - While out_valid && !out_ready, all out_* hold stable.
- ILL ops flow through the pipeline normally with out_result=0 and out_illegal=1.
- flush:
  - Clears s1_valid and returns the FSM to IDLE in the same edge.
  - Does not disturb the output register.
  - Forces in_ready=0 that cycle, so a simultaneous in_valid is dropped.
- shamt=0 → out_result=rs1 for every op.

Optional Feature:
- Macro SHIFT_EXEC_ROTATE_EN.
- Defined:
  - Adds ROL (funct3=001, funct7=0110000, !in_is_imm), ROR (funct3=101, funct7=0110000) and RORI (funct3=101, funct7=0110000, in_is_imm).
  - A rotate occupies two shifter passes:
    - PASS1 computes the primary shift (left for ROL, right for ROR) into a WIDTH-bit partial register.
    - PASS2 shifts the opposite direction by (-shamt) mod WIDTH.
    - result = partial | pass2, with arith=0.
  - in_ready=0 during PASS1 of a rotate.
  - Rotate latency is N+2; throughput is 1 rotate per 2 cycles.
- Undefined: those encodings decode to ILL, and PASS2 and the partial register do not exist.

Decomposition:
- Package shift_pkg holds:
  - Op-code localparams (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_ILL).
  - F3_SL=3'b001 and F3_SR=3'b101.
  - F7_BASE=7'b0000000, F7_ARITH=7'b0100000, F7_ROT=7'b0110000.
  - FSM state encodings.
- Sub-module shift_decode: combinational {funct3, funct7, is_imm} → op.
- The top contains the FSM, the registers and the BarrelShifter instance.

Test Plan:
1. SLL rs1=0x0000_0001, rs2=31, out_ready=1 → out_result=0x8000_0000, out_rd echoed, out_valid exactly one cycle after accept. SLLI with imm=0 → 0x0000_0001.
2. SRA 0x8000_0000 by 4 → 0xF800_0000. SRL same operands → 0x0800_0000. SRAI funct7=0100000 by 31 → 0xFFFF_FFFF.
3. Backpressure: 3 back-to-back ops with out_ready=0 for 4 cycles → in_ready drops after 2 accepts, out_* stable, all 3 results delivered in order once out_ready=1.
4. Illegal: funct3=000 (and SLLI with funct7=0100000) → out_illegal=1, out_result=0. A following legal op is unaffected.
5. flush with s1_valid=1 and in_valid=1 → neither op appears at the output. Pulse rst_n low mid-operation → all outputs 0 immediately, in_ready=1 on the first cycle after release.
6. With SHIFT_EXEC_ROTATE_EN: ROR 0x0000_00F1 by 4 → 0x1000_000F; ROL 0x8000_0001 by 1 → 0x0000_0003; RORI by 0 → unchanged; in_ready=0 in PASS1. Without the macro, the same ops give out_illegal=1.
